keccak_perm_ctrl: RTL and testbench

Sequencing controller for the Keccak-f[400] permutation attached to the shared 400-bit state memory. It detects a CPU start request in the memory control byte and claims the state through the wide port. It then iterates an external combinational round function ROUNDS times on an internal state register and writes the result and status back. It also holds off CPU (AXI) writes for the cycles in which the wide port must write, because the CPU port wins the memory write mux.

---
 rtl/keccak_pkg.sv | 16 +
 rtl/keccak_round_cnt.sv | 25 ++
 rtl/keccak_perm_ctrl.sv | 108 ++++++++++
 tb/tb_keccak_perm_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-f[400] permutation controller:
// FSM state encoding, control-byte bit positions and state width.
package keccak_pkg;
  localparam int STATE_W      = 400;
  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_IRQ_ENA = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLAIM = 2'd1,
    RUN   = 2'd2,
    WB    = 2'd3
  } perm_state_t;
endpackage

// File: rtl/keccak_round_cnt.sv
// Round counter for the permutation: cleared outside RUN, counts up in RUN,
// flags the last round (ROUNDS-1).
module keccak_round_cnt #(
  parameter int ROUNDS = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [4:0] o_cnt,
  output logic       o_tc
);
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  logic [4:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 5'd1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);
endmodule

// File: rtl/keccak_perm_ctrl.sv
// Keccak-f[400] sequencing controller: claims the shared state through the wide
// port, iterates the external round function ROUNDS times, writes back.
// Optional completion interrupt built only when PERM_IRQ_EN is defined.
module keccak_perm_ctrl
  import keccak_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         i_common_clk,
  input  logic         i_rst_n,
  input  logic [399:0] i_v_state_dout,
  input  logic [7:0]   i_v_ctrl_dout,
  input  logic         i_a_wr_req,
  output logic         o_a_stall,
  output logic         o_b_wr,
  output logic [399:0] o_v_state_din,
  output logic [7:0]   o_v_ctrl_din,
  output logic [399:0] o_v_round_in,
  output logic [4:0]   o_v_round_idx,
  input  logic [399:0] i_v_round_out,
  output logic         o_busy,
  output logic         o_irq
);
  perm_state_t          r_state;
  perm_state_t          w_nxt;
  logic [STATE_W-1:0]   r_state_q;
  logic [4:0]           w_cnt;
  logic                 w_tc;
  logic                 w_b_wr;
  logic                 w_stall;
  logic [STATE_W-1:0]   w_state_din;
  logic [7:0]           w_ctrl_din;

  keccak_round_cnt #(.ROUNDS(ROUNDS)) u_cnt (
    .i_clk   (i_common_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (r_state != RUN),
    .i_inc   (r_state == RUN),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_common_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  // CLAIM re-latches every cycle so a contended cycle picks up the CPU's write.
  always_ff @(posedge i_common_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_state_q <= '0;
    else if (r_state == CLAIM) r_state_q <= i_v_state_dout;
    else if (r_state == RUN)   r_state_q <= i_v_round_out;
  end

  // BUSY/DONE are ignored in IDLE so stale memory flags after reset cannot block a start.
  always_comb begin
    w_nxt       = r_state;
    w_b_wr      = 1'b0;
    w_stall     = 1'b0;
    w_state_din = '0;
    w_ctrl_din  = '0;
    case (r_state)
      IDLE: if (i_v_ctrl_dout[CTRL_START]) w_nxt = CLAIM;
      CLAIM: begin
        w_stall                  = 1'b1;
        w_b_wr                   = ~i_a_wr_req;
        w_state_din              = i_v_state_dout;
        w_ctrl_din               = i_v_ctrl_dout;
        w_ctrl_din[CTRL_START]   = 1'b0;
        w_ctrl_din[CTRL_BUSY]    = 1'b1;
        w_ctrl_din[CTRL_DONE]    = 1'b0;
        if (w_b_wr) w_nxt = RUN;
      end
      RUN: if (w_tc) w_nxt = WB;
      WB: begin
        w_stall                  = 1'b1;
        w_b_wr                   = ~i_a_wr_req;
        w_state_din              = r_state_q;
        w_ctrl_din               = i_v_ctrl_dout;
        w_ctrl_din[CTRL_BUSY]    = 1'b0;
        w_ctrl_din[CTRL_DONE]    = 1'b1;
        if (w_b_wr) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  assign o_a_stall     = w_stall;
  assign o_b_wr        = w_b_wr;
  assign o_v_state_din = w_state_din;
  assign o_v_ctrl_din  = w_ctrl_din;
  assign o_v_round_in  = r_state_q;
  assign o_v_round_idx = w_cnt;
  assign o_busy        = (r_state != IDLE);

`ifdef PERM_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_common_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_irq <= 1'b0;
    else          r_irq <= (r_state == WB) && w_b_wr && i_v_ctrl_dout[CTRL_IRQ_ENA];
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Self-checking bench for keccak_perm_ctrl: shared-memory model with CPU-wins
// write mux, +1-per-round function, timing predicted from the latency rules.
module tb_keccak_perm_ctrl;
  localparam int R = 20;
`ifdef PERM_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_wr = 1'b0;
  logic         cpu_ctl = 1'b0;
  logic [399:0] cpu_d = '0;
  logic [399:0] mem_state = '0;
  logic [7:0]   mem_ctrl = '0;
  logic         a_stall, b_wr, busy, irq;
  logic [399:0] state_din, round_in, round_out;
  logic [7:0]   ctrl_din;
  logic [4:0]   round_idx;

  int n_chk = 0;
  int n_err = 0;
  logic [399:0] model_st = '0;

  always #5 clk = ~clk;

  assign round_out = {round_in[399:16], round_in[15:0] + 16'd1};

  always @(posedge clk) begin
    if (a_wr) begin
      if (cpu_ctl) mem_ctrl <= cpu_d[7:0];
      else         mem_state <= cpu_d;
    end else if (b_wr) begin
      mem_state <= state_din;
      mem_ctrl  <= ctrl_din;
    end
  end

  keccak_perm_ctrl #(.ROUNDS(R)) dut (
    .i_common_clk   (clk),
    .i_rst_n        (rst_n),
    .i_v_state_dout (mem_state),
    .i_v_ctrl_dout  (mem_ctrl),
    .i_a_wr_req     (a_wr),
    .o_a_stall      (a_stall),
    .o_b_wr         (b_wr),
    .o_v_state_din  (state_din),
    .o_v_ctrl_din   (ctrl_din),
    .o_v_round_in   (round_in),
    .o_v_round_idx  (round_idx),
    .i_v_round_out  (round_out),
    .o_busy         (busy),
    .o_irq          (irq)
  );

  task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [399:0] rnd400();
    logic [399:0] r = '0;
    for (int i = 0; i < 13; i++) r = (r << 32) | 400'($urandom());
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic wr, input logic ctl, input logic [399:0] d);
    a_wr    = wr;
    cpu_ctl = ctl;
    cpu_d   = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  400'(busy),      '0);
    chk({tag, "_stall"}, 400'(a_stall),   '0);
    chk({tag, "_bwr"},   400'(b_wr),      '0);
    chk({tag, "_irq"},   400'(irq),       '0);
    chk({tag, "_sdin"},  state_din,       '0);
    chk({tag, "_cdin"},  400'(ctrl_din),  '0);
    chk({tag, "_rin"},   round_in,        '0);
    chk({tag, "_ridx"},  400'(round_idx), '0);
  endtask

  // One permutation. Cycle 0 is the first IDLE cycle with START visible.
  // nc/nw: contended cycles at the start of CLAIM/WB. Returns the WB ctrl byte.
  task automatic run_perm(input logic [7:0] ictl, input int nc, input int nw, input bit retrig,
                          input bit skip_start, input int abort_k,
                          output logic [7:0] wbc, output bit aborted);
    logic [399:0] fin;
    int cw, wb0, cwb;
    aborted = 1'b0;
    fin     = '0;
    if (!skip_start) begin
      model_st = rnd400();
      cpu(1'b1, 1'b0, model_st); step();
      cpu(1'b1, 1'b1, 400'(ictl)); step();
      cpu(1'b0, 1'b0, '0);
    end
    cw  = nc + 1;
    wb0 = cw + 1 + R;
    cwb = wb0 + nw;
    wbc = {ictl[7:3], 1'b1, 1'b0, retrig};
    for (int c = (skip_start ? 1 : 0); c <= cwb + 1; c++) begin
      cpu(1'b0, 1'b0, '0);
      if (c >= 1 && c <= nc) begin
        model_st = rnd400();
        cpu(1'b1, 1'b0, model_st);
      end else if (c > cw && c < wb0 && c - cw - 1 == 3 && retrig) begin
        cpu(1'b1, 1'b1, 400'({ictl[7:3], 3'b011}));
      end else if (c > cw && c < wb0 && c - cw - 1 == 5) begin
        cpu(1'b1, 1'b0, rnd400());
      end else if (c >= wb0 && c < cwb) begin
        cpu(1'b1, 1'b0, rnd400());
      end
      if (abort_k >= 0 && c == cw + 1 + abort_k) begin
        cpu(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        aborted = 1'b1;
        return;
      end
      @(negedge clk);
      chk("busy",  400'(busy),    400'(c >= 1 && c <= cwb));
      chk("stall", 400'(a_stall), 400'((c >= 1 && c <= cw) || (c >= wb0 && c <= cwb)));
      chk("bwr",   400'(b_wr),    400'(c == cw || c == cwb));
      chk("irq",   400'(irq),     400'(c == cwb + 1 && IRQ_EN && ictl[7]));
      if (c == cw) begin
        chk("claim_state", state_din, model_st);
        chk("claim_ctrl",  400'(ctrl_din), 400'({ictl[7:3], 3'b010}));
        fin = {model_st[399:16], model_st[15:0] + 16'(R)};
      end
      if (c > cw && c < wb0) begin
        chk("ridx", 400'(round_idx), 400'(c - cw - 1));
        chk("rin",  round_in, {model_st[399:16], model_st[15:0] + 16'(c - cw - 1)});
      end
      if (c == cwb) begin
        chk("wb_state", state_din, fin);
        chk("wb_ctrl",  400'(ctrl_din), 400'(wbc));
      end
      step();
    end
    model_st = fin;
  endtask

  initial begin
    logic [7:0] wbc, ictl;
    bit ab;
    int nc, nw;
    bit rt;
    #1;
    chk_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    run_perm(8'h01, 0, 0, 1'b0, 1'b0, -1, wbc, ab);
    run_perm(8'h01, 1, 2, 1'b0, 1'b0, -1, wbc, ab);
    run_perm(8'h01, 0, 0, 1'b1, 1'b0, -1, wbc, ab);
    chk("retrig_wbc", 400'(wbc), 400'(8'h05));
    run_perm(wbc, 0, 0, 1'b0, 1'b1, -1, wbc, ab);
    run_perm(8'h81, 0, 1, 1'b0, 1'b0, -1, wbc, ab);

    run_perm(8'h01, 0, 0, 1'b0, 1'b0, 7, wbc, ab);
    chk("aborted", 400'(ab), 400'(1));
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 400'(busy), '0);
      chk("post_rst_bwr",  400'(b_wr), '0);
      step();
    end
    run_perm(8'h03, 1, 1, 1'b0, 1'b0, -1, wbc, ab);

    for (int it = 0; it < 6; it++) begin
      ictl = 8'($urandom()) | 8'h01;
      nc   = int'($urandom_range(0, 3));
      nw   = int'($urandom_range(0, 3));
      rt   = 1'($urandom_range(0, 1));
      run_perm(ictl, nc, nw, rt, 1'b0, -1, wbc, ab);
      if (rt) run_perm(wbc, int'($urandom_range(0, 2)), 0, 1'b0, 1'b1, -1, wbc, ab);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
